if_id_reg: RTL

IF/ID pipeline register of the five-stage MIPS core. It sits directly downstream of the PC register and instruction memory. It captures the fetched instruction, its PC and fetch-side exception information, and presents them to the decode stage. It supports hazard stalls, pipeline flushes, and branch-delay-slot tagging, and keeps saturating stall and flush event counters for the performance/debug CP0 view.

---
 rtl/co_pkg.sv | 22 ++
 rtl/if_fault_check.sv | 21 ++
 rtl/if_id_reg.sv | 121 ++++++++++++
 3 files changed

// File: rtl/co_pkg.sv
// ============================================================================
// Module   : co_pkg
// Purpose  : Shared constants for the MIPS core front end (fetch bounds,
//            exception codes, bubble encoding).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package co_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_LAST  = 32'h0000_6FFC;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  localparam logic [31:0] NOP      = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/if_fault_check.sv
// ============================================================================
// Module   : if_fault_check
// Purpose  : Flags a fetch address that is misaligned or outside [base, last].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fault_check (
  input  logic [31:0] pc_i,
  input  logic [31:0] base_i,
  input  logic [31:0] last_i,
  output logic        fault_o
);

  always_comb begin
    fault_o = (pc_i[1:0] != 2'b00) || (pc_i < base_i) || (pc_i > last_i);
  end

endmodule

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register with stall, flush, delay-slot tagging,
//            fetch-fault capture and saturating stall/flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg #(
  parameter logic [31:0] PC_RESET = co_pkg::PC_RESET,
  parameter logic [31:0] IM_BASE  = co_pkg::IM_BASE,
  parameter logic [31:0] IM_LAST  = co_pkg::IM_LAST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  input  logic        bd_f,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic [4:0]  exc_d,
  output logic        bd_d,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  import co_pkg::EXC_NONE;
  import co_pkg::EXC_ADEL;
  import co_pkg::NOP;

  logic        fault;

  logic [31:0] instr_q,     instr_d_n;
  logic [31:0] pc_q,        pc_d_n;
  logic [31:0] pc8_q,       pc8_d_n;
  logic        valid_q,     valid_d_n;
  logic [4:0]  exc_q,       exc_d_n;
  logic        bd_q,        bd_d_n;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  if_fault_check u_fault_check (
    .pc_i    (pc_f),
    .base_i  (IM_BASE),
    .last_i  (IM_LAST),
    .fault_o (fault)
  );

  // Flush beats stall; a stalled cycle holds every field and only counts.
  always_comb begin
    instr_d_n   = instr_q;
    pc_d_n      = pc_q;
    pc8_d_n     = pc8_q;
    valid_d_n   = valid_q;
    exc_d_n     = exc_q;
    bd_d_n      = bd_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (flush) begin
      instr_d_n = NOP;
      pc_d_n    = pc_f;
      pc8_d_n   = pc_f + 32'd8;
      valid_d_n = 1'b0;
      exc_d_n   = EXC_NONE;
      bd_d_n    = 1'b0;
      if (flush_cnt_q != 16'hFFFF) begin
        flush_cnt_d = flush_cnt_q + 16'd1;
      end
    end else if (stall) begin
      if (stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end else begin
      pc_d_n    = pc_f;
      pc8_d_n   = pc_f + 32'd8;
      valid_d_n = 1'b1;
      bd_d_n    = bd_f;
      instr_d_n = fault ? NOP : instr_f;
      exc_d_n   = fault ? EXC_ADEL : EXC_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q     <= NOP;
      pc_q        <= PC_RESET;
      pc8_q       <= PC_RESET + 32'd8;
      valid_q     <= 1'b0;
      exc_q       <= EXC_NONE;
      bd_q        <= 1'b0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      instr_q     <= instr_d_n;
      pc_q        <= pc_d_n;
      pc8_q       <= pc8_d_n;
      valid_q     <= valid_d_n;
      exc_q       <= exc_d_n;
      bd_q        <= bd_d_n;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign instr_d   = instr_q;
  assign pc_d      = pc_q;
  assign pc8_d     = pc8_q;
  assign valid_d   = valid_q;
  assign exc_d     = exc_q;
  assign bd_d      = bd_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire
